// File: rtl/arb_low4.sv
// rtl/arb_low4.sv - four-way round-robin arbiter with active-low grants and optional hold limit
// Optional hold-limit revocation is enabled by defining ARB_LOW4_TIMEOUT_EN.
module arb_low4 #(
   parameter int MAXHOLD = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic r0,
   input  logic r1,
   input  logic r2,
   input  logic r3,
   output logic g0,
   output logic g1,
   output logic g2,
   output logic g3,
   output logic s0,
   output logic s1,
   output logic busy,
   output logic timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [7:0] MAX_C = 8'(MAXHOLD);

   state_t      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  sel_q, sel_d;
   logic [7:0]  hold_q, hold_d;
   logic [3:0]  gnt_q, gnt_d;
   logic        busy_q, busy_d;
   logic        to_q, to_d;

   logic [3:0]  req;
   logic [1:0]  win;
   logic [1:0]  cand;
   logic        found;

   assign req = {r3, r2, r1, r0};

   // Search starts one past the previous grantee; k = 4 wraps back to last itself.
   always_comb begin
      win   = 2'd0;
      cand  = 2'd0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               sel_d   = win;
               last_d  = win;
               hold_d  = 8'd0;
            end
         end
         GRANT: begin
            if (hold_q != MAX_C) begin
               hold_d = hold_q + 8'd1;
            end
            if (!req[sel_q]) begin
               state_d = GAP;
            end
`ifdef ARB_LOW4_TIMEOUT_EN
            // A request drop on the limit cycle takes the branch above: plain release.
            else if (hold_q == MAX_C - 8'd1) begin
               state_d = GAP;
               to_d    = 1'b1;
            end
`endif
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == GRANT);
      gnt_d  = busy_d ? ~(4'b0001 << sel_d) : 4'hF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         sel_q   <= 2'd0;
         hold_q  <= 8'd0;
         gnt_q   <= 4'hF;
         busy_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         to_q    <= to_d;
      end
   end

   assign g0      = gnt_q[0];
   assign g1      = gnt_q[1];
   assign g2      = gnt_q[2];
   assign g3      = gnt_q[3];
   assign s0      = sel_q[0];
   assign s1      = sel_q[1];
   assign busy    = busy_q;
   assign timeout = to_q;

endmodule

// File: tb/tb_arb_low4.sv
// tb/tb_arb_low4.sv - scoreboard bench for arb_low4 (MAXHOLD = 4; timeout checks under ARB_LOW4_TIMEOUT_EN)
module tb_arb_low4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
   logic g0, g1, g2, g3, s0, s1, busy, timeout;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] expq[$];

   arb_low4 #(.MAXHOLD(4)) dut (
      .clk(clk), .rst(rst),
      .r0(r0), .r1(r1), .r2(r2), .r3(r3),
      .g0(g0), .g1(g1), .g2(g2), .g3(g3),
      .s0(s0), .s1(s1), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Expected word layout: {timeout, busy, s1, s0, g3, g2, g1, g0}
   function automatic logic [7:0] gv(input int i);
      logic [3:0] g;
      g = 4'b0001;
      g = ~(g << i);
      return {1'b0, 1'b1, 2'(i), g};
   endfunction

   function automatic logic [7:0] idl(input int s, input logic to);
      return {to, 1'b0, 2'(s), 4'hF};
   endfunction

   task automatic step(input logic rs, input logic [3:0] r, input logic [7:0] e);
      @(negedge clk);
      rst = rs;
      {r3, r2, r1, r0} = r;
      expq.push_back(e);
   endtask

   always @(posedge clk) begin
      logic [7:0] act, exp_v;
      logic [3:0] gl;
      #1;
      act = {timeout, busy, s1, s0, g3, g2, g1, g0};
      gl  = ~{g3, g2, g1, g0};
      if ($countones(gl) > 1 || (gl != 4'd0 && (!busy || gl != (4'b0001 << {s1, s0})))) begin
         n_err++;
         $display("FAIL invariant t=%0t got %b required one-hot low grant matching s and busy", $time, act);
      end
      if (expq.size() != 0) begin
         exp_v = expq.pop_front();
         n_vec++;
         if (act !== exp_v) begin
            n_err++;
            $display("FAIL vector %0d t=%0t got %b required %b", n_vec, $time, act, exp_v);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, then r0 and r2 requesting: requester 0 wins first.
      step(1, 4'b0000, idl(0, 0));
      step(1, 4'b0101, idl(0, 0));
      step(0, 4'b0101, gv(0));
      step(0, 4'b0000, idl(0, 0));
      step(0, 4'b0000, idl(0, 0));

      // All requesting, each grantee drops for one cycle: 0,1,2,3,0.
      step(1, 4'b1111, idl(0, 0));
      step(0, 4'b1111, gv(0));
      step(0, 4'b1110, idl(0, 0));
      step(0, 4'b1111, idl(0, 0));
      step(0, 4'b1111, gv(1));
      step(0, 4'b1101, idl(1, 0));
      step(0, 4'b1111, idl(1, 0));
      step(0, 4'b1111, gv(2));
      step(0, 4'b1011, idl(2, 0));
      step(0, 4'b1111, idl(2, 0));
      step(0, 4'b1111, gv(3));
      step(0, 4'b0111, idl(3, 0));
      step(0, 4'b1111, idl(3, 0));
      step(0, 4'b1111, gv(0));
      step(0, 4'b1111, gv(0));
      step(0, 4'b1110, idl(0, 0));
      step(0, 4'b0000, idl(0, 0));

      // Reset during a grant to 3, then r0 and r3 contend: 0 wins.
      step(0, 4'b1000, gv(3));
      step(0, 4'b1000, gv(3));
      step(1, 4'b1001, idl(0, 0));
      step(0, 4'b1001, gv(0));
      step(0, 4'b0000, idl(0, 0));
      step(0, 4'b0000, idl(0, 0));

      // r1 held continuously.
      step(0, 4'b0010, gv(1));
`ifdef ARB_LOW4_TIMEOUT_EN
      for (int i = 0; i < 3; i++) step(0, 4'b0010, gv(1));
      step(0, 4'b0010, idl(1, 1));
      step(0, 4'b0010, idl(1, 0));
      step(0, 4'b0010, gv(1));
      for (int i = 0; i < 3; i++) step(0, 4'b0010, gv(1));
      step(0, 4'b0011, idl(1, 1));
      step(0, 4'b0011, idl(1, 0));
      step(0, 4'b0011, gv(0));
      for (int i = 0; i < 3; i++) step(0, 4'b0011, gv(0));
      step(0, 4'b0010, idl(0, 0));
      step(0, 4'b0000, idl(0, 0));
`else
      for (int i = 0; i < 120; i++) step(0, 4'b0010, gv(1));
      step(0, 4'b0000, idl(1, 0));
      step(0, 4'b0000, idl(1, 0));
`endif

      repeat (3) @(posedge clk);
      #2;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arb_low4.md
ARB_LOW4 -- requirements
Module: arb_low4

Interface
REQ-001 The block SHALL have parameter MAXHOLD, default 15, giving the maximum number of consecutive cycles one grant may be held (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports r0, r1, r2, r3, input, 1 each, active-high requests from requesters 0..3.
REQ-005 The block SHALL have ports g0, g1, g2, g3, output, 1 each, active-low one-hot grants.
REQ-006 The block SHALL have ports s0, s1, output, 1 each, binary index of the current grantee (s1 is the MSB), for driving a 2-to-4 active-low select decoder.
REQ-007 The block SHALL have port busy, output, 1, high while any grant is asserted.
REQ-008 The block SHALL have port timeout, output, 1, a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-009 All outputs SHALL be registered, with no combinational path from r0..r3 to any output.
REQ-010 The block SHALL implement three states: IDLE, GRANT and GAP.
REQ-011 In IDLE with at least one request high at edge n, the block SHALL enter GRANT with exactly one gX low, and s1:s0 = X and busy = 1, visible after edge n (1-cycle latency).
REQ-012 The winner SHALL be the first requester with r high, searching round-robin from (last+1) mod 4, where last is the previous grantee.
REQ-013 In IDLE with no request, all grants SHALL stay high and the state SHALL stay IDLE.
REQ-014 In GRANT, the grant SHALL be held while the grantee's request stays high; requests from other requesters SHALL have no effect.
REQ-015 In GRANT, if the grantee's request is low at an edge, the block SHALL enter GAP and release all grants (g0..g3 = 1, busy = 0).
REQ-016 GAP SHALL last exactly one cycle with all grants high, then return to IDLE; this guarantees break-before-make between grantees.
REQ-017 s1:s0 SHALL hold its last value outside GRANT; consumers qualify it with busy.
REQ-018 last SHALL update to the grantee index on entry to GRANT.
REQ-019 A hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle, saturating and never wrapping.
REQ-020 A simultaneous request drop and hold-limit expiry SHALL be treated as a normal release, with timeout = 0.
REQ-021 At most one of g0..g3 SHALL be low in any cycle, and a low gX SHALL imply busy = 1 and s1:s0 = X.

Reset
REQ-022 While rst = 1 at an edge, the block SHALL set state = IDLE, g0..g3 = 1, s0 = s1 = 0, busy = 0, timeout = 0, hold counter = 0 and last = 3, so that requester 0 has first priority.
REQ-023 Reset asserted during GRANT SHALL drop the grant after that edge, with no GAP cycle and no timeout pulse.
REQ-024 Requests sampled on the reset edge SHALL be ignored; arbitration resumes on the first edge with rst = 0.

Configuration
REQ-025 With macro ARB_LOW4_TIMEOUT_EN defined, a grant held for MAXHOLD cycles with its request still high SHALL be revoked: the block enters GAP and pulses timeout for one cycle, coincident with the GAP cycle.
REQ-026 With ARB_LOW4_TIMEOUT_EN undefined, the hold limit SHALL not exist, a grant SHALL be held for as long as its request stays high, and timeout SHALL be tied to 0.
REQ-027 After a timeout, the revoked requester SHALL have lowest priority in the next arbitration, per REQ-012.

Verification
REQ-028 The bench SHALL apply reset, then r0 = r2 = 1 -> expect g0 = 0, s1:s0 = 00 and busy = 1 one cycle after the first edge with rst = 0.
REQ-029 The bench SHALL hold r0..r3 all = 1 and drop each grantee's request for one cycle after a grant -> expect grant order 0, 1, 2, 3, 0 with one all-high GAP cycle between grants.
REQ-030 The bench SHALL hold r1 = 1 continuously with MAXHOLD = 4 and ARB_LOW4_TIMEOUT_EN defined -> expect g1 low for 4 cycles, then one GAP cycle with timeout = 1, then re-grant to 1 only if no other request is high.
REQ-031 The bench SHALL repeat the REQ-030 stimulus without ARB_LOW4_TIMEOUT_EN -> expect g1 low for 100+ cycles and timeout always 0.
REQ-032 The bench SHALL assert rst mid-GRANT with r3 = 1 -> expect g0..g3 = 1, s1:s0 = 00 and busy = 0 after that edge, then g0 wins if r0 = r3 = 1 after reset.
REQ-033 The bench SHALL check continuously that at most one gX is low and that gX low implies s1:s0 = X.
